// File: rtl/mode_key_controller.sv
// Debounces three active-low buttons and turns their press events into flash-mode and LED-mask updates.
// Latency: raw low to output is DEBOUNCE_CYCLES+2 edges. Buttons cannot be stalled; change is a one-cycle strobe with no handshake.
module mode_key_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_led_n,
    input  logic       key_all_n,
    output logic [3:0] mode_select,
    output logic [7:0] led_select,
    output logic       change
);

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam int K_MODE = 0;
    localparam int K_LED  = 1;
    localparam int K_ALL  = 2;

    logic [2:0]  raw;
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  level;
    logic [2:0]  press;
    logic [23:0] cnt [3];
    logic [7:0]  shadow;

    logic [3:0]  mode_nxt;
    logic [7:0]  led_nxt;
    logic [7:0]  shadow_nxt;
    logic        change_nxt;

    assign raw = {key_all_n, key_led_n, key_mode_n};

    // Press is registered alongside the level flip, so outputs land one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
            level <= 3'b111;
            press <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= 24'd0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    cnt[i] <= 24'd0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= 24'd0;
                    press[i] <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 24'd1;
                end
            end
        end
    end

    always_comb begin
        mode_nxt   = mode_select;
        led_nxt    = led_select;
        shadow_nxt = shadow;
        change_nxt = |press;

        if (press[K_MODE]) begin
            mode_nxt = (mode_select == 4'd3) ? 4'd0 : mode_select + 4'd1;
        end

        // The all-toggle wins over a coincident LED advance.
        if (press[K_ALL]) begin
            if (led_select == 8'hFF) begin
                led_nxt = shadow;
            end else begin
                shadow_nxt = led_select;
                led_nxt    = 8'hFF;
            end
        end else if (press[K_LED]) begin
            if (led_select == 8'hFF) begin
                led_nxt = 8'h01;
            end else begin
                led_nxt = {led_select[6:0], led_select[7]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_select <= 4'd0;
            led_select  <= 8'h01;
            shadow      <= 8'h01;
            change      <= 1'b0;
        end else begin
            mode_select <= mode_nxt;
            led_select  <= led_nxt;
            shadow      <= shadow_nxt;
            change      <= change_nxt;
        end
    end

endmodule

// File: tb/tb_mode_key_controller.sv
// Directed bench for mode_key_controller with a scoreboard of expected change events.
module tb_mode_key_controller;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       key_led_n  = 1'b1;
    logic       key_all_n  = 1'b1;
    logic [3:0] mode_select;
    logic [7:0] led_select;
    logic       change;

    typedef struct {
        int         cyc;
        logic [3:0] mode;
        logic [7:0] led;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] m_mode   = 4'd0;
    logic [7:0] m_led    = 8'h01;
    logic [7:0] m_shadow = 8'h01;

    mode_key_controller #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_mode_n (key_mode_n),
        .key_led_n  (key_led_n),
        .key_all_n  (key_all_n),
        .mode_select(mode_select),
        .led_select (led_select),
        .change     (change)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every change strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (change) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_change observed=1 expected=0 at cyc %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.cyc));
                check("event_mode", {28'd0, mode_select}, {28'd0, e.mode});
                check("event_led", {24'd0, led_select}, {24'd0, e.led});
            end
        end
    end

    task automatic model(input logic m, input logic l, input logic a);
        if (m) m_mode = (m_mode == 4'd3) ? 4'd0 : m_mode + 4'd1;
        if (a) begin
            if (m_led == 8'hFF) m_led = m_shadow;
            else begin
                m_shadow = m_led;
                m_led    = 8'hFF;
            end
        end else if (l) begin
            m_led = (m_led == 8'hFF) ? 8'h01 : {m_led[6:0], m_led[7]};
        end
    endtask

    task automatic press(input logic m, input logic l, input logic a);
        exp_t e;
        @(negedge clk);
        key_mode_n = ~m;
        key_led_n  = ~l;
        key_all_n  = ~a;
        model(m, l, a);
        e.cyc  = cyc + DB + 3;
        e.mode = m_mode;
        e.led  = m_led;
        sb.push_back(e);
        repeat (10) @(negedge clk);
        key_mode_n = 1'b1;
        key_led_n  = 1'b1;
        key_all_n  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, {28'd0, mode_select}, 32'd0);
        check({tag, "_led"}, {24'd0, led_select}, 32'h01);
        check({tag, "_change"}, {31'd0, change}, 32'd0);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_reset_vals("idle");

        repeat (5) press(1'b1, 1'b0, 1'b0);
        check("mode_after_5", {28'd0, mode_select}, 32'd1);

        // Glitch one short of the debounce count: must produce no strobe.
        @(negedge clk);
        key_led_n = 1'b0;
        repeat (DB - 1) @(negedge clk);
        key_led_n = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_led", {24'd0, led_select}, 32'h01);

        repeat (8) press(1'b0, 1'b1, 1'b0);
        check("led_wrap", {24'd0, led_select}, 32'h01);

        repeat (2) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        check("all_then_led", {24'd0, led_select}, 32'h01);

        repeat (2) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        check("all_restore", {24'd0, led_select}, 32'h04);

        repeat (2) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b1);
        check("simul_led", {24'd0, led_select}, 32'hFF);
        check("simul_mode", {28'd0, mode_select}, 32'd3);

        // Reset in the middle of a debounce with the key kept low.
        @(negedge clk);
        key_mode_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("mid_reset");
        m_mode   = 4'd0;
        m_led    = 8'h01;
        m_shadow = 8'h01;
        rst = 1'b0;
        model(1'b1, 1'b0, 1'b0);
        e.cyc  = cyc + DB + 3;
        e.mode = m_mode;
        e.led  = m_led;
        sb.push_back(e);
        repeat (12) @(negedge clk);
        key_mode_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_mode", {28'd0, mode_select}, 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mode_key_controller.md
MODE_KEY_CONTROLLER -- requirements
Module: mode_key_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the consecutive stable cycles needed to accept a key level (20 ms at 50 MHz; legal range 1 to 2^24-1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port key_mode_n, input, 1 bit: raw mode button, active-low, asynchronous to clk.
REQ-005 The block SHALL have port key_led_n, input, 1 bit: raw LED-advance button, active-low, asynchronous to clk.
REQ-006 The block SHALL have port key_all_n, input, 1 bit: raw all-LED toggle button, active-low, asynchronous to clk.
REQ-007 The block SHALL have port mode_select, output, 4 bits: flash-mode index for the driver selector; values 0-3 only.
REQ-008 The block SHALL have port led_select, output, 8 bits: LED enable mask for the mode drivers.
REQ-009 The block SHALL have port change, output, 1 bit: one-cycle pulse that marks an update of mode_select or led_select.

Function
REQ-010 Each key SHALL pass through a 2-flop synchronizer before any other logic sees it.
REQ-011 Each key SHALL have its own debounce counter and debounced level.
- Synchronized value equal to the debounced level: the counter clears to 0.
- Value differs and counter == DEBOUNCE_CYCLES-1: the debounced level takes the synchronized value and the counter clears.
- Value differs otherwise: the counter increments.
REQ-012 A press event SHALL be a 1->0 transition of the debounced level, one cycle wide; a 0->1 transition (release) SHALL produce no event.
REQ-013 Latency: for a raw low held stable from sampling edge E0, registered outputs SHALL update on edge E0+DEBOUNCE_CYCLES+2.
REQ-014 A key glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event and SHALL clear that key's counter.
REQ-015 On a mode press, mode_select SHALL step 0->1->2->3->0; it SHALL never hold a value of 4 or more.
REQ-016 A led press with led_select one-hot SHALL rotate the mask left by one, with 8'h80 wrapping to 8'h01.
REQ-017 A led press with led_select == 8'hFF SHALL set led_select to 8'h01.
REQ-018 An all press with led_select != 8'hFF SHALL copy led_select into a shadow register and set led_select to 8'hFF.
REQ-019 An all press with led_select == 8'hFF SHALL restore led_select from the shadow register.
REQ-020 Simultaneous all and led events in the same cycle SHALL apply only the all event; the led event is discarded.
REQ-021 A mode event SHALL be applied independently of, and in the same cycle as, any LED event.
REQ-022 change SHALL be asserted for exactly one cycle, on the same edge that any applied event updates an output, including updates to an unchanged value.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL load these values:
- mode_select = 4'd0
- led_select = 8'h01
- shadow = 8'h01
- change = 0
- synchronizer flops and debounced levels = 1 (released)
- all counters = 0
REQ-024 rst asserted during a partial debounce count SHALL discard the count.
REQ-025 A key still held low when rst deasserts SHALL produce exactly one press event, DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset then idle 20 cycles -> mode_select=0, led_select=8'h01, change never high.
REQ-027 key_mode_n low for 10 cycles, done 5 times -> mode_select steps 1,2,3,0,1, each update on the 6th edge after the drop, with one change pulse per update.
REQ-028 key_led_n 3-cycle low glitch, then 8 full presses -> no event from the glitch; led_select steps 02,04,...,80,01.
REQ-029 led_select=8'h04, key_all press -> 8'hFF; key_led press -> 8'h01.
REQ-030 Repeat the sequence in REQ-029 with a second key_all press instead of the key_led press -> led_select returns to 8'h04.
REQ-031 Drop key_all_n and key_led_n on the same edge together with key_mode_n, from led_select=8'h10 and mode_select=2 -> led_select=8'hFF and mode_select=3 on the same edge, with a single change pulse.
REQ-032 rst pulse mid-debounce with the key held low -> all outputs at reset values, then one event exactly 6 edges after rst falls.
